riscv_data_mem: RTL
===================

Name: riscv_data_mem

Overview:
- Parametrised data-memory block for the single-cycle and upcoming multi-cycle RISC-V cores. It replaces the ad-hoc word array used in core benches.
- Adds byte-addressed word access, per-byte write strobes and a configurable response latency with a ready handshake.
- Flags out-of-range, misaligned and conflicting accesses, and counts completed reads and writes.
- Sits between the core's DataMem* interface and the bench or SoC top.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8 and a power of two.
- DEPTH, 1024, number of words.
- ADDR_W, 32, width of the byte address.
- LATENCY, 0, wait cycles before a response; 0 to 7 are legal.
- CNT_W, 16, width of the access counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- DataMemAddr  in  ADDR_W  byte address.
- DataMemRead  in  1  read request.
- DataMemWrite  in  1  write request.
- DataMemWData  in  DATA_W  write data.
- DataMemWStrb  in  DATA_W/8  byte-lane write enables; bit k enables byte k.
- DataMemRData  out  DATA_W  read data; valid only while DataMemReady=1.
- DataMemReady  out  1  response/completion strobe.
- DataMemErr  out  1  error strobe; asserted together with DataMemReady.
- RdCount  out  CNT_W  number of completed error-free reads.
- WrCount  out  CNT_W  number of completed error-free writes.

Behaviour:
- Reset (RST=1 at a rising edge): FSM goes to IDLE and the wait counter to 0. RdCount=0, WrCount=0.
- Outputs during reset: DataMemReady=0, DataMemErr=0, DataMemRData=0.
- Memory contents are NOT cleared by reset. The bench may preload them hierarchically.
- Word index = DataMemAddr >> log2(DATA_W/8). Byte offset = the low log2(DATA_W/8) bits.
- Error conditions, any of which makes an access an error:
  - byte offset != 0;
  - word index >= DEPTH;
  - DataMemRead and DataMemWrite both asserted.
- Error access behaviour: no memory update, DataMemRData=0, DataMemErr=1 with DataMemReady, counters unchanged.
- Write with DataMemWStrb=0: completes normally, memory is unchanged, WrCount still increments.

LATENCY=0 (combinational mode, matching the single-cycle core):
- DataMemReady = DataMemRead | DataMemWrite, combinationally in the same cycle.
- DataMemRData = mem[index] combinationally.
- A write commits the strobed bytes at the rising edge of the request cycle.
- Counters update at that same edge.

LATENCY=N>0 (FSM mode):
- IDLE: a request is seen at an edge. The block latches address, data, strobe and type, loads the counter with N-1 and moves to WAIT. If N=1 it goes directly to RESP.
- WAIT: the counter decrements each edge; at 0 the FSM moves to RESP.
- RESP: DataMemReady=1 (registered output) and DataMemRData holds the latched read result.
  - A write commits at the edge that leaves RESP; counters update at that edge.
  - Next state is IDLE.
- Request inputs are ignored outside IDLE. The requester must hold them until DataMemReady.
- The response appears N cycles after the request cycle. There is no back-to-back overlap: minimum spacing between accepted requests is N+1 cycles.
- Read data is sampled from memory at the edge that leaves WAIT (or IDLE when N=1), so a read returns memory contents as of that edge.
- Reset asserted in WAIT or RESP aborts the access: pending write dropped, no counter update, Ready=0 on the next cycle.

Counters: saturate at 2^CNT_W-1; they do not wrap.

Test Plan:
- LATENCY=0, DATA_W=32: write 0xDEADBEEF to addr 0x40 with strb 4'hF, then read 0x40 -> same-cycle Ready=1, RData=0xDEADBEEF, WrCount=1, RdCount=1.
- Byte strobe: preload word 0x10 with 0x11223344, write 0xAABBCCDD with strb 4'b0101, read back -> 0x11BB33DD.
- Errors:
  - read 0x42 (misaligned) -> Ready=1, Err=1, RData=0;
  - write 0x1000 with DEPTH=1024 (index 1024) -> Err=1 and memory unchanged;
  - Read and Write both set -> Err=1;
  - counters unchanged in all three cases.
- LATENCY=3: read issued at cycle 0 -> Ready=1 only in cycle 3. A second request is held at cycles 1-2 and is not accepted until cycle 4.
- Reset mid-operation, LATENCY=3: write 0x5 to 0x20, assert RST in cycle 2 -> word 0x20 keeps its old value, WrCount=0, Ready stays 0.
- Saturation with CNT_W=4: 20 valid reads -> RdCount=15.

Source files
------------

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: byte-addressed data memory with per-byte write strobes for the RISC-V cores.
// LATENCY=0 answers combinationally; LATENCY>0 runs an IDLE/WAIT/RESP request FSM.
module riscv_data_mem #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 0,
    parameter int CNT_W   = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   DataMemAddr,
    input  logic                DataMemRead,
    input  logic                DataMemWrite,
    input  logic [DATA_W-1:0]   DataMemWData,
    input  logic [DATA_W/8-1:0] DataMemWStrb,
    output logic [DATA_W-1:0]   DataMemRData,
    output logic                DataMemReady,
    output logic                DataMemErr,
    output logic [CNT_W-1:0]    RdCount,
    output logic [CNT_W-1:0]    WrCount
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;

    logic [ADDR_W-1:0] w_word_idx;
    logic [IDX_W-1:0]  w_idx;
    logic              w_off_err;
    logic              w_range_err;
    logic              w_req;
    logic              w_req_err;

    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [BYTES-1:0]  w_wstrb;
    logic              w_rd_done;
    logic              w_wr_done;

    // Range check is done on the full word index so high address bits cannot alias into the array
    assign w_word_idx  = DataMemAddr >> OFF_W;
    assign w_idx       = w_word_idx[IDX_W-1:0];
    assign w_off_err   = (DataMemAddr & ADDR_W'(BYTES - 1)) != '0;
    assign w_range_err = {1'b0, w_word_idx} >= (ADDR_W + 1)'(DEPTH);
    assign w_req       = DataMemRead | DataMemWrite;
    assign w_req_err   = w_off_err | w_range_err | (DataMemRead & DataMemWrite);

    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wstrb[b]) begin
                    r_mem[w_waddr][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Counters stick at all-ones instead of wrapping
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_done && (r_rd_cnt != {CNT_W{1'b1}})) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
            if (w_wr_done && (r_wr_cnt != {CNT_W{1'b1}})) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
        end
    end

    assign RdCount = r_rd_cnt;
    assign WrCount = r_wr_cnt;

    generate
        if (LATENCY == 0) begin : g_comb
            assign w_we         = DataMemWrite & ~w_req_err & ~RST;
            assign w_waddr      = w_idx;
            assign w_wdata      = DataMemWData;
            assign w_wstrb      = DataMemWStrb;
            assign w_rd_done    = DataMemRead & ~w_req_err & ~RST;
            assign w_wr_done    = w_we;
            assign DataMemReady = w_req & ~RST;
            assign DataMemErr   = w_req & w_req_err & ~RST;
            assign DataMemRData = w_rd_done ? r_mem[w_idx] : '0;
        end else begin : g_fsm
            localparam logic [1:0] S_IDLE = 2'd0;
            localparam logic [1:0] S_WAIT = 2'd1;
            localparam logic [1:0] S_RESP = 2'd2;

            logic [1:0]        r_state;
            logic [2:0]        r_wait;
            logic              r_ready;
            logic [IDX_W-1:0]  r_idx;
            logic [DATA_W-1:0] r_wdata;
            logic [BYTES-1:0]  r_wstrb;
            logic [DATA_W-1:0] r_rdata;
            logic              r_is_rd;
            logic              r_is_wr;
            logic              r_err;
            logic              w_sample;
            logic              w_rd_ok;
            logic [IDX_W-1:0]  w_rd_idx;
            logic              w_commit;

            // Read data is captured on the edge that enters RESP
            assign w_sample = ((r_state == S_IDLE) && w_req && (LATENCY == 1)) ||
                              ((r_state == S_WAIT) && (r_wait <= 3'd1));
            assign w_rd_idx = (r_state == S_IDLE) ? w_idx : r_idx;
            assign w_rd_ok  = (r_state == S_IDLE) ? (DataMemRead & ~w_req_err)
                                                  : (r_is_rd & ~r_err);
            assign w_commit = (r_state == S_RESP) & ~r_err & ~RST;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_state <= S_IDLE;
                    r_wait  <= '0;
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                    r_is_rd <= 1'b0;
                    r_is_wr <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_req) begin
                                r_idx   <= w_idx;
                                r_wdata <= DataMemWData;
                                r_wstrb <= DataMemWStrb;
                                r_is_rd <= DataMemRead;
                                r_is_wr <= DataMemWrite;
                                r_err   <= w_req_err;
                                if (LATENCY == 1) begin
                                    r_state <= S_RESP;
                                    r_ready <= 1'b1;
                                end else begin
                                    r_state <= S_WAIT;
                                    r_wait  <= 3'(LATENCY - 1);
                                end
                            end
                        end
                        S_WAIT: begin
                            if (r_wait <= 3'd1) begin
                                r_state <= S_RESP;
                                r_ready <= 1'b1;
                                r_wait  <= '0;
                            end else begin
                                r_wait <= r_wait - 3'd1;
                            end
                        end
                        S_RESP: begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b0;
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b0;
                        end
                    endcase
                    if (w_sample) begin
                        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
                    end
                end
            end

            assign w_we         = w_commit & r_is_wr;
            assign w_waddr      = r_idx;
            assign w_wdata      = r_wdata;
            assign w_wstrb      = r_wstrb;
            assign w_rd_done    = w_commit & r_is_rd;
            assign w_wr_done    = w_we;
            assign DataMemReady = r_ready;
            assign DataMemErr   = r_ready & r_err;
            assign DataMemRData = r_ready ? r_rdata : '0;
        end
    endgenerate

endmodule
